// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side feeder: launch FSM states and
// default widths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } tx_state_t;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned ADDR_W_DEFAULT = 4;

endpackage

// File: rtl/uart_fifo_buf.sv
// Byte FIFO in front of the UART launcher: register file, wrapping read/write
// pointers and an occupancy counter. full/empty are decoded from the registered
// count, so a push while full is refused even if a pop happens in the same cycle.
module uart_fifo_buf
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes from producers and launches them one at a time into the UART
// transmitter: one-cycle tx_start with tx_din held until tx_done_tick.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_din,
    input  logic              tx_done_tick,
    output logic              busy
);

    tx_state_t         state;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rd_data;

    // Pop exactly on the IDLE->START edge, the same edge that loads tx_din.
    assign fifo_pop = (state == IDLE) && !empty;
    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

    uart_fifo_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .pop     (fifo_pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Launch FSM; tx_din is only ever loaded when leaving IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tx_din <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state  <= START;
                        tx_din <= fifo_rd_data;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (tx_done_tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky record that a producer byte was dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

endmodule
